adc16dv160_input_read: RTL and testbench



---
 rtl/adc16dv160_input_common_pkg.sv | 33 +++
 rtl/adc16dv160_input_evcnt.sv | 45 ++++
 rtl/adc16dv160_input_read.sv | 179 +++++++++++++++++
 tb/tb_adc16dv160_input_read.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc16dv160_input_common_pkg.sv
// adc16dv160_input_common: shared constants for the ADC16DV160 input AXI4-Lite slave.
// Holds the register byte offsets, SR bit positions, AXI response codes and
// the read-side FSM state type. Used by both the read and write logic.
package adc16dv160_input_common;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned OFFSET_W   = 8;

  // Register byte offsets within the 256-byte window
  localparam logic [OFFSET_W-1:0] AXI_ADDR_CR           = 8'h00;
  localparam logic [OFFSET_W-1:0] AXI_ADDR_DSIZE        = 8'h04;
  localparam logic [OFFSET_W-1:0] AXI_ADDR_SR           = 8'h08;
  localparam logic [OFFSET_W-1:0] AXI_ADDR_LS_START_THR = 8'h0C;
  localparam logic [OFFSET_W-1:0] AXI_ADDR_LS_STOP_THR  = 8'h10;
  localparam logic [OFFSET_W-1:0] AXI_ADDR_LS_N_START   = 8'h14;
  localparam logic [OFFSET_W-1:0] AXI_ADDR_LS_N_STOP    = 8'h18;
  localparam logic [OFFSET_W-1:0] AXI_ADDR_EVCNT        = 8'h1C;

  // SR bit positions
  localparam int unsigned SR_BUSY_BIT = 0;
  localparam int unsigned SR_DONE_BIT = 1;
  localparam int unsigned SR_OVF_BIT  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/adc16dv160_input_evcnt.sv
// adc16dv160_input_evcnt: saturating 32-bit event counter with clear-on-read.
// An event in the same cycle as a clear wins: the count restarts at 1.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   evt_i      single-cycle event pulse
//   clr_i      clear request (read handshake of EVCNT)
//   cnt_o      registered count value
module adc16dv160_input_evcnt
  import adc16dv160_input_common::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  evt_i,
  input  logic                  clr_i,
  output logic [AXI_DATA_W-1:0] cnt_o
);

  logic [AXI_DATA_W-1:0] cnt_q;
  logic [AXI_DATA_W-1:0] cnt_d;

  // Next count: event beats clear, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (evt_i) begin
      if (clr_i) begin
        cnt_d = AXI_DATA_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + AXI_DATA_W'(1);
      end
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adc16dv160_input_read.sv
// adc16dv160_input_read: AXI4-Lite read responder for the ADC16DV160 input block.
// Returns CR/DSIZE/threshold readbacks, a status register with sticky done/ovf
// bits and an overflow event counter; SR and EVCNT clear on read.
// Optional feature macro: ADC16DV160_INPUT_RD_SLVERR_EN (unmapped -> SLVERR).
// Ports:
//   ACLK, ARESET                   clock, asynchronous active-high reset
//   ARADDR/ARVALID/ARREADY         AXI read address channel
//   RDATA/RRESP/RVALID/RREADY      AXI read data channel
//   dsize, cr_*, ls_*              readback values from the write side
//   st_busy, st_done, st_ovf       live busy level, done and overflow pulses
module adc16dv160_input_read
  import adc16dv160_input_common::*;
#(
  parameter int unsigned ADDR_LSB = 2,
  parameter int unsigned DECODE_W = 6
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [AXI_ADDR_W-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [AXI_DATA_W-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic [31:0]           dsize,
  input  logic                  cr_test,
  input  logic                  cr_rt,
  input  logic                  cr_ls,
  input  logic [15:0]           ls_start_thr,
  input  logic [15:0]           ls_stop_thr,
  input  logic [31:0]           ls_n_start,
  input  logic [31:0]           ls_n_stop,
  input  logic                  st_busy,
  input  logic                  st_done,
  input  logic                  st_ovf
);

  localparam logic [DECODE_W-1:0] IDX_CR    = DECODE_W'(AXI_ADDR_CR >> ADDR_LSB);
  localparam logic [DECODE_W-1:0] IDX_DSIZE = DECODE_W'(AXI_ADDR_DSIZE >> ADDR_LSB);
  localparam logic [DECODE_W-1:0] IDX_SR    = DECODE_W'(AXI_ADDR_SR >> ADDR_LSB);
  localparam logic [DECODE_W-1:0] IDX_STRT  = DECODE_W'(AXI_ADDR_LS_START_THR >> ADDR_LSB);
  localparam logic [DECODE_W-1:0] IDX_STOP  = DECODE_W'(AXI_ADDR_LS_STOP_THR >> ADDR_LSB);
  localparam logic [DECODE_W-1:0] IDX_NSTRT = DECODE_W'(AXI_ADDR_LS_N_START >> ADDR_LSB);
  localparam logic [DECODE_W-1:0] IDX_NSTOP = DECODE_W'(AXI_ADDR_LS_N_STOP >> ADDR_LSB);
  localparam logic [DECODE_W-1:0] IDX_EVCNT = DECODE_W'(AXI_ADDR_EVCNT >> ADDR_LSB);

  rd_state_e             state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  done_q, ovf_q;

  logic [DECODE_W-1:0]   key;
  logic [AXI_DATA_W-1:0] rdata_c;
  logic [1:0]            rresp_c;
  logic [AXI_DATA_W-1:0] sr_c;
  logic [AXI_DATA_W-1:0] evcnt;
  logic                  hit_sr_c, hit_ev_c;
  logic                  rd_sr_c, rd_ev_c;
  logic                  ar_hs, r_hs;

  // Address bits outside the decode window are deliberately ignored
  logic unused_addr;
  assign unused_addr = ^{ARADDR[AXI_ADDR_W-1:ADDR_LSB+DECODE_W], ARADDR[ADDR_LSB-1:0]};

  assign key   = ARADDR[ADDR_LSB+DECODE_W-1:ADDR_LSB];
  assign ar_hs = ARVALID & arready_q;
  assign r_hs  = RREADY & rvalid_q;

  // Status register snapshot (pre-clear values)
  always_comb begin
    sr_c              = '0;
    sr_c[SR_BUSY_BIT] = st_busy;
    sr_c[SR_DONE_BIT] = done_q;
    sr_c[SR_OVF_BIT]  = ovf_q;
  end

  // Read data decode
  always_comb begin
    rdata_c  = '0;
    rresp_c  = RESP_OKAY;
    hit_sr_c = 1'b0;
    hit_ev_c = 1'b0;
    case (key)
      IDX_CR:    rdata_c = {28'b0, cr_ls, cr_rt, cr_test, 1'b0};
      IDX_DSIZE: rdata_c = dsize;
      IDX_SR: begin
        rdata_c  = sr_c;
        hit_sr_c = 1'b1;
      end
      IDX_STRT:  rdata_c = {16'b0, ls_start_thr};
      IDX_STOP:  rdata_c = {16'b0, ls_stop_thr};
      IDX_NSTRT: rdata_c = ls_n_start;
      IDX_NSTOP: rdata_c = ls_n_stop;
      IDX_EVCNT: begin
        rdata_c  = evcnt;
        hit_ev_c = 1'b1;
      end
      default: begin
`ifdef ADC16DV160_INPUT_RD_SLVERR_EN
        rresp_c = RESP_SLVERR;
`else
        rresp_c = RESP_OKAY;
`endif
      end
    endcase
  end

  // Read FSM next state and registered-output next values
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rd_sr_c = 1'b0;
    rd_ev_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          state_d = S_RESP;
          rdata_d = rdata_c;
          rresp_d = rresp_c;
          rd_sr_c = hit_sr_c;
          rd_ev_c = hit_ev_c;
        end
      end
      S_RESP: begin
        if (r_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    arready_d = (state_d == S_IDLE);
    rvalid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Sticky status bits: a new event overrides a same-cycle clear
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= st_done | (done_q & ~rd_sr_c);
      ovf_q  <= st_ovf | (ovf_q & ~rd_sr_c);
    end
  end

  adc16dv160_input_evcnt u_evcnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .evt_i (st_ovf),
    .clr_i (rd_ev_c),
    .cnt_o (evcnt)
  );

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_adc16dv160_input_read.sv
// Directed testbench for adc16dv160_input_read.
module tb_adc16dv160_input_read;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] dsize;
  logic        cr_test, cr_rt, cr_ls;
  logic [15:0] ls_start_thr, ls_stop_thr;
  logic [31:0] ls_n_start, ls_n_stop;
  logic        st_busy, st_done, st_ovf;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [1:0]  unmapped_resp;

  adc16dv160_input_read dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .ARADDR       (ARADDR),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .dsize        (dsize),
    .cr_test      (cr_test),
    .cr_rt        (cr_rt),
    .cr_ls        (cr_ls),
    .ls_start_thr (ls_start_thr),
    .ls_stop_thr  (ls_stop_thr),
    .ls_n_start   (ls_n_start),
    .ls_n_stop    (ls_n_stop),
    .st_busy      (st_busy),
    .st_done      (st_done),
    .st_ovf       (st_ovf)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // One full read; optional st_ovf during the AR handshake cycle or the hold cycles
  task automatic do_read(input logic [31:0] addr, input int hold,
                         input logic ovf_in_hs, input logic ovf_in_hold,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    ARADDR  = addr;
    ARVALID = 1'b1;
    st_ovf  = ovf_in_hs;
    cyc = 0;
    while (!ARREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!ARREADY) check("ar_timeout", 32'(ARREADY), 32'h1);
    tick();
    ARVALID = 1'b0;
    st_ovf  = 1'b0;
    check("rvalid_lat", 32'(RVALID), 32'h1);
    data = RDATA;
    resp = RRESP;
    for (int i = 0; i < hold; i++) begin
      st_ovf = ovf_in_hold;
      check("hold_arready", 32'(ARREADY), 32'h0);
      check("hold_rvalid", 32'(RVALID), 32'h1);
      check("hold_rdata", RDATA, data);
      tick();
    end
    st_ovf = 1'b0;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rvalid_drop", 32'(RVALID), 32'h0);
    check("arready_back", 32'(ARREADY), 32'h1);
  endtask

  task automatic pulse_ovf();
    st_ovf = 1'b1;
    tick();
    st_ovf = 1'b0;
    tick();
  endtask

  initial begin
`ifdef ADC16DV160_INPUT_RD_SLVERR_EN
    unmapped_resp = 2'b10;
`else
    unmapped_resp = 2'b00;
`endif
    ARESET = 1'b1;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    dsize = 32'h1234_5678;
    cr_test = 1'b1; cr_rt = 1'b0; cr_ls = 1'b1;
    ls_start_thr = 16'hABCD; ls_stop_thr = 16'h0123;
    ls_n_start = 32'hDEAD_BEEF; ls_n_stop = 32'h0000_0010;
    st_busy = 1'b0; st_done = 1'b0; st_ovf = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_arready", 32'(ARREADY), 32'h0);
    check("rst_rvalid", 32'(RVALID), 32'h0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_rresp", 32'(RRESP), 32'h0);
    ARESET = 1'b0;
    tick();
    check("post_rst_arready", 32'(ARREADY), 32'h1);

    // Plain readbacks
    do_read(32'h0000_0000, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("cr_data", rd_data, 32'h0000_000A);
    check("cr_resp", 32'(rd_resp), 32'h0);
    do_read(32'h0000_0004, 5, 1'b0, 1'b0, rd_data, rd_resp);
    check("dsize_data", rd_data, 32'h1234_5678);
    do_read(32'h1000_0006, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("dsize_alias", rd_data, 32'h1234_5678);
    do_read(32'h0000_000C, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("start_thr", rd_data, 32'h0000_ABCD);
    do_read(32'h0000_0010, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("stop_thr", rd_data, 32'h0000_0123);
    do_read(32'h0000_0014, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("n_start", rd_data, 32'hDEAD_BEEF);
    do_read(32'h0000_0018, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("n_stop", rd_data, 32'h0000_0010);

    // Event counter and clear-on-read
    pulse_ovf(); pulse_ovf(); pulse_ovf();
    do_read(32'h0000_001C, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("evcnt_3", rd_data, 32'h3);
    do_read(32'h0000_001C, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("evcnt_clr", rd_data, 32'h0);

    // Sticky status bits
    do_read(32'h0000_0008, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("sr_ovf_sticky", rd_data, 32'h4);
    do_read(32'h0000_0008, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("sr_clr", rd_data, 32'h0);
    st_busy = 1'b1;
    st_done = 1'b1;
    tick();
    st_done = 1'b0;
    tick();
    do_read(32'h0000_0008, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("sr_done", rd_data, 32'h3);
    do_read(32'h0000_0008, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("sr_busy_only", rd_data, 32'h1);

    // Event coinciding with clear: event wins
    do_read(32'h0000_0008, 0, 1'b1, 1'b0, rd_data, rd_resp);
    check("sr_hs_ovf_snap", rd_data, 32'h1);
    do_read(32'h0000_0008, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("sr_hs_ovf_kept", rd_data, 32'h5);
    do_read(32'h0000_001C, 0, 1'b1, 1'b0, rd_data, rd_resp);
    check("evcnt_hs_snap", rd_data, 32'h1);
    do_read(32'h0000_001C, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("evcnt_hs_kept", rd_data, 32'h1);
    do_read(32'h0000_001C, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("evcnt_hs_clr", rd_data, 32'h0);

    // Events during a held response leave RDATA alone but still count
    do_read(32'h0000_001C, 3, 1'b0, 1'b1, rd_data, rd_resp);
    check("evcnt_held", rd_data, 32'h0);
    do_read(32'h0000_001C, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("evcnt_during_hold", rd_data, 32'h3);

    // Unmapped offset
    do_read(32'h0000_0040, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("unmapped_data", rd_data, 32'h0);
    check("unmapped_resp", 32'(rd_resp), 32'(unmapped_resp));

    // Reset mid-transaction
    st_busy = 1'b0;
    pulse_ovf();
    ARADDR  = 32'h0000_0008;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    check("mid_rvalid", 32'(RVALID), 32'h1);
    ARESET = 1'b1;
    #1;
    check("async_rvalid", 32'(RVALID), 32'h0);
    check("async_arready", 32'(ARREADY), 32'h0);
    tick();
    ARESET = 1'b0;
    tick();
    check("rel_arready", 32'(ARREADY), 32'h1);
    do_read(32'h0000_001C, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("rst_evcnt", rd_data, 32'h0);
    do_read(32'h0000_0008, 0, 1'b0, 1'b0, rd_data, rd_resp);
    check("rst_sr", rd_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
